// File: rtl/seq_div.sv
// seq_div -- multi-cycle restoring integer divider, one quotient bit per clock.
//
// Optional feature macro: SEQ_DIV_SIGNED_EN
//   defined   : signed_op selects two's-complement operands. Magnitudes are
//               taken on entry and signs are applied in the FIX state.
//   undefined : signed_op is ignored and every operation is unsigned. The
//               latency is the same in both builds.
//
// Ports
//   clock        rising-edge clock
//   clear_n      asynchronous active-low reset
//   start        division request, sampled only in IDLE
//   signed_op    1 = signed operands, sampled with start
//   dividend     numerator, sampled with start
//   divisor      denominator, sampled with start
//   busy         high from the accepting edge until done rises
//   done         one-cycle completion pulse
//   quotient     registered quotient, held until the next done
//   remainder    registered remainder, held until the next done
//   div_by_zero  registered zero-divisor flag, updated with each done
module seq_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a;      // dividend magnitude, shifted into quotient bits
  logic [WIDTH-1:0] r_m;      // divisor magnitude
  logic [WIDTH:0]   r_p;      // partial remainder
  logic [CW-1:0]    r_cnt;
  logic             r_zero;

  logic             r_done;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic             w_accept;
  logic             w_div_zero;
  logic             w_last;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_t;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_div_zero = (divisor == '0);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  // One restoring step: shift {P, A} left, then try to subtract M.
  // P < M always holds, so the shifted P fits in WIDTH+1 bits and the
  // borrow shows up in bit WIDTH of the difference.
  assign w_shift = {r_p[WIDTH-1:0], r_a[WIDTH-1]};
  assign w_t     = w_shift - {1'b0, r_m};

`ifdef SEQ_DIV_SIGNED_EN
  logic w_neg_dvd;
  logic w_neg_dvs;
  logic r_qsign;
  logic r_rsign;

  assign w_neg_dvd = signed_op & dividend[WIDTH-1];
  assign w_neg_dvs = signed_op & divisor[WIDTH-1];
  // The most negative value negates to itself, which is the correct
  // unsigned magnitude 2^(WIDTH-1).
  assign w_dvd_mag = w_neg_dvd ? ('0 - dividend) : dividend;
  assign w_dvs_mag = w_neg_dvs ? ('0 - divisor) : divisor;
  assign w_quo_fix = r_qsign ? ('0 - r_a) : r_a;
  assign w_rem_fix = r_rsign ? ('0 - r_p[WIDTH-1:0]) : r_p[WIDTH-1:0];

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_qsign <= 1'b0;
      r_rsign <= 1'b0;
    end else if (w_accept) begin
      r_qsign <= w_neg_dvd ^ w_neg_dvs;
      r_rsign <= w_neg_dvd;
    end
  end
`else
  logic w_unused_sgn;

  assign w_unused_sgn = signed_op;
  assign w_dvd_mag    = dividend;
  assign w_dvs_mag    = divisor;
  assign w_quo_fix    = r_a;
  assign w_rem_fix    = r_p[WIDTH-1:0];
`endif

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_div_zero ? S_FIX : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_next = S_FIX;
        end
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_a    <= '0;
      r_m    <= '0;
      r_p    <= '0;
      r_cnt  <= '0;
      r_zero <= 1'b0;
    end else if (w_accept) begin
      // On a zero divisor A keeps the raw dividend so FIX can return it
      // unchanged as the remainder, whatever the signedness.
      r_a    <= w_div_zero ? dividend : w_dvd_mag;
      r_m    <= w_dvs_mag;
      r_p    <= '0;
      r_cnt  <= '0;
      r_zero <= w_div_zero;
    end else if (r_state == S_RUN) begin
      r_p   <= w_t[WIDTH] ? w_shift : w_t;
      r_a   <= {r_a[WIDTH-2:0], ~w_t[WIDTH]};
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_done <= 1'b0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);
      if (r_state == S_FIX) begin
        r_quo <= r_zero ? '1 : w_quo_fix;
        r_rem <= r_zero ? r_a : w_rem_fix;
        r_dbz <= r_zero;
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign quotient    = r_quo;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (WIDTH=32). The expected results come from
// plain integer division in the bench, with signed mode following the
// SEQ_DIV_SIGNED_EN build option.
module tb_seq_div;

  localparam int unsigned W = 32;
`ifdef SEQ_DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic         clock;
  logic         clear_n;
  logic         start;
  logic         signed_op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;

  seq_div #(.WIDTH(W)) dut (
    .clock      (clock),
    .clear_n    (clear_n),
    .start      (start),
    .signed_op  (signed_op),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division, remainder follows dividend sign,
  // zero divisor gives all-ones quotient and the raw dividend.
  function automatic void model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa;
    longint sb;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else if (sgn && SIGNED_EN) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
      z  = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!done && n < limit);
  endtask

  task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    int           n;
    model(sgn, a, b, eq, er, ez);
    @(negedge clock);
    start     = 1'b1;
    signed_op = sgn;
    dividend  = a;
    divisor   = b;
    @(posedge clock);
    #1;
    chk({tag, "_busy_hi"}, 64'(busy), 64'(1));
    @(negedge clock);
    start     = 1'b0;
    signed_op = 1'($urandom);
    dividend  = $urandom;
    divisor   = $urandom;
    wait_done(200, n);
    chk({tag, "_lat"}, 64'(n), (b == '0) ? 64'(1) : 64'(W + 1));
    chk({tag, "_q"}, 64'(quotient), 64'(eq));
    chk({tag, "_r"}, 64'(remainder), 64'(er));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(ez));
    chk({tag, "_busy_lo"}, 64'(busy), 64'(0));
    @(posedge clock);
    #1;
    chk({tag, "_done_pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    int n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    int           sel;

    clear_n   = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #1;
    chk("rst_q", 64'(quotient), 64'(0));
    chk("rst_r", 64'(remainder), 64'(0));
    chk("rst_flags", 64'({busy, done, div_by_zero}), 64'(0));
    repeat (3) @(posedge clock);
    @(negedge clock);
    clear_n = 1'b1;

    run_div("u100_7", 1'b0, 32'd100, 32'd7);
    run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    run_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("u_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("dz_1234", 1'b0, 32'h0000_1234, 32'd0);
    run_div("u9_3", 1'b0, 32'd9, 32'd3);
    run_div("dz_signed", 1'b1, 32'hFFFF_FF00, 32'd0);
    run_div("s_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    run_div("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);

    // A second start while busy must be ignored.
    @(negedge clock);
    start = 1'b1; signed_op = 1'b0; dividend = 32'd20; divisor = 32'd3;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    start = 1'b1; dividend = 32'd99; divisor = 32'd9;
    @(negedge clock);
    start = 1'b0;
    wait_done(200, n);
    chk("hs_lat", 64'(n), 64'(W + 1 - 10));
    chk("hs_q", 64'(quotient), 64'(6));
    chk("hs_r", 64'(remainder), 64'(2));
    repeat (W + 4) begin
      @(posedge clock);
      #1;
      chk("hs_no_extra_done", 64'(done), 64'(0));
    end

    // start held high: back-to-back results.
    @(negedge clock);
    start = 1'b1; signed_op = 1'b0; dividend = 32'd50; divisor = 32'd5;
    wait_done(200, n);
    chk("b2b_first_lat", 64'(n), 64'(W + 2));
    chk("b2b_first_q", 64'(quotient), 64'(10));
    wait_done(200, n);
    chk("b2b_gap", 64'(n), 64'(W + 2));
    chk("b2b_second_q", 64'(quotient), 64'(10));
    chk("b2b_second_r", 64'(remainder), 64'(0));
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #1;
    chk("b2b_stop_idle", 64'(busy), 64'(0));

    // Reset in the middle of a division.
    @(negedge clock);
    start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    clear_n = 1'b0;
    #1;
    chk("mid_rst_q", 64'(quotient), 64'(0));
    chk("mid_rst_r", 64'(remainder), 64'(0));
    chk("mid_rst_flags", 64'({busy, done, div_by_zero}), 64'(0));
    repeat (2) @(negedge clock);
    clear_n = 1'b1;
    n = 0;
    repeat (W + 4) begin
      @(posedge clock);
      #1;
      if (done) n++;
    end
    chk("mid_rst_no_done", 64'(n), 64'(0));
    run_div("post_rst", 1'b0, 32'hFFFF_FFFF, 32'h10);

    // Randomized operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      sel = int'($urandom_range(0, 4));
      a   = $urandom;
      if (sel == 0)      b = '0;
      else if (sel == 1) b = W'($urandom_range(1, 15));
      else if (sel == 2) b = '1;
      else               b = $urandom;
      run_div("rnd", 1'($urandom), a, b);
    end

    model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, eq, er, ez);
    chk("model_min_m1_q", 64'(eq), SIGNED_EN ? 64'h8000_0000 : 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
